// File: rtl/gfx_cmdq_pkg.sv
// gfx_cmdq_pkg: shared definitions for the graphics command queue.
// Contents: register offsets within the iomem window, STATUS bit positions,
// the IRQCFG enable bit index and the bus acknowledge FSM state type.
package gfx_cmdq_pkg;

  localparam logic [7:0] OFF_CMD     = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_IRQCFG  = 8'h08;
  localparam logic [7:0] OFF_CTRL    = 8'h0C;
  localparam logic [7:0] OFF_PUSHCNT = 8'h10;

  localparam int unsigned STATUS_EMPTY_BIT = 16;
  localparam int unsigned STATUS_FULL_BIT  = 17;

  localparam int unsigned IRQCFG_EN_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_GAP
  } ack_state_t;

endpackage

// File: rtl/gfx_cmdq_fifo.sv
// gfx_cmdq_fifo: first-word-fall-through FIFO over a register array.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write one word (ignored when full)
//   pop           advance the head (ignored when empty)
//   flush         drop all contents; overrides a same-cycle pop
//   rdata         current head word
//   level         number of stored words (0..DEPTH)
//   empty, full   derived from the registered pointers
module gfx_cmdq_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [31:0]              wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [31:0]              rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [31:0]   r_mem [DEPTH];
  logic [LW-1:0] r_wptr;
  logic [LW-1:0] r_rptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[LW-1] != r_rptr[LW-1]) && (r_wptr[LW-2:0] == r_rptr[LW-2:0]);
  assign level = r_wptr - r_rptr;
  assign rdata = r_mem[r_rptr[LW-2:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push && !full) begin
        r_mem[r_wptr[LW-2:0]] <= wdata;
        r_wptr                <= r_wptr + LW'(1);
      end
      if (pop && !empty) begin
        r_rptr <= r_rptr + LW'(1);
      end
    end
  end

endmodule

// File: rtl/gfx_cmdq.sv
// gfx_cmdq: memory-mapped command queue feeding the graphics pipeline.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   iomem_valid/ready/wstrb/
//   iomem_addr/wdata/rdata     CPU iomem responder (wstrb == 0 is a read)
//   cmd_valid/ready/data       FWFT command stream to the graphics core
//   irq                        registered low-water interrupt (level)
// Register window at BASE: CMD 0x00, STATUS 0x04, IRQCFG 0x08, CTRL 0x0C,
// PUSHCNT 0x10; all other offsets read 0 and ignore writes.
module gfx_cmdq
  import gfx_cmdq_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'h0300_0000,
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_data,
  output logic        irq
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [31:0] IRQCFG_MASK =
    (32'(1) << IRQCFG_EN_BIT) | ((32'(1) << LW) - 32'(1));

  ack_state_t    r_state;
  logic [31:0]   r_irqcfg;
  logic [31:0]   r_pushcnt;
  logic          r_irq;

  logic          w_hit;
  logic [7:0]    w_off;
  logic          w_is_push;
  logic          w_take;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_cfg_wr;
  logic [31:0]   w_cfg_merged;
  logic [31:0]   w_status;
  logic [31:0]   w_rd_val;
  logic [LW-1:0] w_level;
  logic [LW-1:0] w_level_next;
  logic          w_empty;
  logic          w_full;

  assign w_hit     = iomem_valid && (iomem_addr[31:8] == BASE[31:8]);
  assign w_off     = iomem_addr[7:0];
  assign w_is_push = (w_off == OFF_CMD) && (iomem_wstrb == 4'b1111);
  // A full-strobe push into a full FIFO is held off, not acknowledged.
  assign w_take    = (r_state == ST_IDLE) && w_hit && !(w_is_push && w_full);
  assign w_push    = w_take && w_is_push;
  assign w_flush   = w_take && (w_off == OFF_CTRL) && iomem_wstrb[0] && iomem_wdata[0];
  assign w_cfg_wr  = w_take && (w_off == OFF_IRQCFG) && (iomem_wstrb != 4'b0000);
  assign w_pop     = !w_empty && cmd_ready;

  assign cmd_valid = !w_empty;
  assign irq       = r_irq;

  gfx_cmdq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (w_push),
    .wdata (iomem_wdata),
    .pop   (w_pop),
    .flush (w_flush),
    .rdata (cmd_data),
    .level (w_level),
    .empty (w_empty),
    .full  (w_full)
  );

  always_comb begin
    w_level_next = w_level;
    if (w_flush) begin
      w_level_next = '0;
    end else begin
      if (w_push) w_level_next = w_level_next + LW'(1);
      if (w_pop)  w_level_next = w_level_next - LW'(1);
    end
  end

  always_comb begin
    w_cfg_merged = r_irqcfg;
    for (int unsigned b = 0; b < 4; b++) begin
      if (iomem_wstrb[b]) w_cfg_merged[8*b +: 8] = iomem_wdata[8*b +: 8];
    end
  end

  always_comb begin
    w_status                   = '0;
    w_status[LW-1:0]           = w_level;
    w_status[STATUS_EMPTY_BIT] = w_empty;
    w_status[STATUS_FULL_BIT]  = w_full;
    case (w_off)
      OFF_STATUS:  w_rd_val = w_status;
      OFF_IRQCFG:  w_rd_val = r_irqcfg;
      OFF_PUSHCNT: w_rd_val = r_pushcnt;
      default:     w_rd_val = '0;
    endcase
  end

  // GAP keeps ready low for one cycle after each ack so a lingering
  // iomem_valid is not accepted twice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            iomem_ready <= 1'b1;
            iomem_rdata <= w_rd_val;
            r_state     <= ST_ACK;
          end
        end
        ST_ACK: begin
          iomem_ready <= 1'b0;
          iomem_rdata <= '0;
          r_state     <= ST_GAP;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irqcfg  <= '0;
      r_pushcnt <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_cfg_wr) r_irqcfg  <= w_cfg_merged & IRQCFG_MASK;
      if (w_push)   r_pushcnt <= r_pushcnt + 32'd1;
      r_irq <= r_irqcfg[IRQCFG_EN_BIT] && (w_level_next <= r_irqcfg[LW-1:0]);
    end
  end

endmodule

// File: tb/tb_gfx_cmdq.sv
module tb_gfx_cmdq;

  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam logic [31:0] A_CMD     = BASE + 32'h00;
  localparam logic [31:0] A_STATUS  = BASE + 32'h04;
  localparam logic [31:0] A_IRQCFG  = BASE + 32'h08;
  localparam logic [31:0] A_CTRL    = BASE + 32'h0C;
  localparam logic [31:0] A_PUSHCNT = BASE + 32'h10;
  localparam logic [31:0] A_HOLE    = BASE + 32'h20;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        irq;

  gfx_cmdq #(.BASE(BASE), .DEPTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic [31:0] val;
  } sb_t;

  sb_t         sb_bus[$];
  logic [31:0] sb_cmd[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        flush_win = 1'b0;
  logic        prev_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: ack pulses are checked against queued read expectations, and
  // every accepted command word against the queue of pushed words.
  always @(negedge clk) begin
    if (iomem_ready) begin
      check("ack_width", {31'd0, prev_ready}, 32'd0);
      if (sb_bus.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_bus.pop_front();
        if (e.chk) check("rdata", iomem_rdata, e.val);
      end
    end
    prev_ready = iomem_ready;
    if (cmd_valid && cmd_ready && !flush_win) begin
      if (sb_cmd.size() == 0) begin
        check("unexpected_pop", 32'd1, 32'd0);
      end else begin
        logic [31:0] w;
        w = sb_cmd.pop_front();
        check("cmd_data", cmd_data, w);
      end
    end
  end

  // Called #1 after a posedge with the DUT idle; returns the same way.
  task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] wdata, input logic chk, input logic [31:0] exp);
    sb_t e;
    int  n;
    e.chk = chk;
    e.val = exp;
    sb_bus.push_back(e);
    if (addr == A_CMD && strb == 4'b1111) sb_cmd.push_back(wdata);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = strb;
    iomem_wdata = wdata;
    @(posedge clk); #1;
    check("ack_latency", {31'd0, iomem_ready}, 32'd1);
    n = 0;
    while (!iomem_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!iomem_ready) void'(sb_bus.pop_back());
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    bus(addr, 4'b0000, 32'd0, 1'b1, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata);
    bus(addr, strb, wdata, 1'b0, 32'd0);
  endtask

  task automatic pulse_ready();
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lvl;
    int n;
    reset       = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    iomem_addr  = '0;
    iomem_wdata = '0;
    cmd_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_ready", {31'd0, iomem_ready}, 32'd0);
    check("rst_rdata", iomem_rdata, 32'd0);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_cmd_data", cmd_data, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rd(A_STATUS, 32'h0001_0000);
    rd(A_IRQCFG, 32'h0000_0000);
    rd(A_PUSHCNT, 32'h0000_0000);

    // Single push, head visible
    wr(A_CMD, 4'b1111, 32'hDEAD_BEEF);
    check("push_cmd_valid", {31'd0, cmd_valid}, 32'd1);
    check("push_cmd_data", cmd_data, 32'hDEAD_BEEF);
    rd(A_STATUS, 32'h0000_0001);
    rd(A_PUSHCNT, 32'h0000_0001);
    pulse_ready();
    check("pop_empty", {31'd0, cmd_valid}, 32'd0);
    rd(A_STATUS, 32'h0001_0000);

    // Fill to 16 (pointers start at 1, so this wraps), then stall the 17th
    for (int i = 0; i < 16; i++) wr(A_CMD, 4'b1111, 32'h1000_0000 + 32'(i));
    rd(A_STATUS, 32'h0002_0010);
    begin
      sb_t e;
      e.chk = 1'b0;
      e.val = '0;
      sb_bus.push_back(e);
      sb_cmd.push_back(32'h1000_0010);
      iomem_valid = 1'b1;
      iomem_addr  = A_CMD;
      iomem_wstrb = 4'b1111;
      iomem_wdata = 32'h1000_0010;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        check("stall_ready", {31'd0, iomem_ready}, 32'd0);
      end
      pulse_ready();
      check("stall_after_pop", {31'd0, iomem_ready}, 32'd0);
      @(posedge clk); #1;
      check("stall_ack", {31'd0, iomem_ready}, 32'd1);
      iomem_valid = 1'b0;
      iomem_wstrb = 4'b0000;
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    rd(A_STATUS, 32'h0002_0010);
    rd(A_PUSHCNT, 32'd18);
    cmd_ready = 1'b1;
    n = 0;
    while (cmd_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    cmd_ready = 1'b0;
    check("drain_done", {31'd0, cmd_valid}, 32'd0);
    check("drain_queue", 32'(sb_cmd.size()), 32'd0);

    // Low-water interrupt
    wr(A_IRQCFG, 4'b1111, 32'h8000_0002);
    rd(A_IRQCFG, 32'h8000_0002);
    for (int i = 0; i < 4; i++) wr(A_CMD, 4'b1111, 32'hA000_0000 + 32'(i));
    check("irq_level4", {31'd0, irq}, 32'd0);
    lvl = 4;
    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (lvl > 0) lvl--;
      check("irq_drain", {31'd0, irq}, (lvl <= 2) ? 32'd1 : 32'd0);
    end
    cmd_ready = 1'b0;
    wr(A_IRQCFG, 4'b1000, 32'h0000_0000);
    check("irq_disabled", {31'd0, irq}, 32'd0);
    rd(A_IRQCFG, 32'h0000_0002);

    // Flush with a concurrent cmd_ready: the head must not be consumed
    for (int i = 0; i < 5; i++) wr(A_CMD, 4'b1111, 32'hB000_0000 + 32'(i));
    rd(A_STATUS, 32'h0000_0005);
    begin
      sb_t e;
      e.chk = 1'b1;
      e.val = 32'd0;
      sb_bus.push_back(e);
      flush_win   = 1'b1;
      cmd_ready   = 1'b1;
      iomem_valid = 1'b1;
      iomem_addr  = A_CTRL;
      iomem_wstrb = 4'b1111;
      iomem_wdata = 32'd1;
      @(posedge clk); #1;
      check("flush_ack", {31'd0, iomem_ready}, 32'd1);
      check("flush_cmd_valid", {31'd0, cmd_valid}, 32'd0);
      cmd_ready   = 1'b0;
      flush_win   = 1'b0;
      sb_cmd.delete();
      iomem_valid = 1'b0;
      iomem_wstrb = 4'b0000;
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    rd(A_STATUS, 32'h0001_0000);
    rd(A_PUSHCNT, 32'd27);
    rd(A_CTRL, 32'd0);

    // Partial-strobe push and unmapped offset: acknowledged, no effect
    wr(A_CMD, 4'b0001, 32'hC0DE_0001);
    wr(A_HOLE, 4'b1111, 32'hFFFF_FFFF);
    rd(A_STATUS, 32'h0001_0000);
    rd(A_HOLE, 32'd0);
    rd(A_CMD, 32'd0);
    rd(A_PUSHCNT, 32'd27);
    check("final_cmd_valid", {31'd0, cmd_valid}, 32'd0);

    @(posedge clk); #1;
    check("sb_bus_empty", 32'(sb_bus.size()), 32'd0);
    check("sb_cmd_empty", 32'(sb_cmd.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
